// File: rtl/eq_pkg.sv
// Shared constants and types for the equalizer datapath: sample/band
// geometry defaults, channel codes and the band scheduler state encoding.
package eq_pkg;

  localparam int DW     = 24;  // sample width, signed two's complement
  localparam int NBANDS = 5;   // EQ bands per channel
  localparam int BW     = 3;   // band index width

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/eq_band_sched_if.sv
// Link between the band scheduler and the shared biquad engine.
//
// Handshake: eng_start is a one-cycle request; eng_chan, eng_band and
// eng_din are valid with it and stay stable until the engine answers.
// eng_done is a one-cycle response with eng_dout valid in that same cycle.
// Exactly one operation is outstanding at a time, so no ready signal exists.
interface eq_band_sched_if #(
  parameter int DW = eq_pkg::DW,
  parameter int BW = eq_pkg::BW
) ();

  logic          eng_start;
  logic          eng_chan;
  logic [BW-1:0] eng_band;
  logic [DW-1:0] eng_din;
  logic          eng_done;
  logic [DW-1:0] eng_dout;

  modport master (
    output eng_start, eng_chan, eng_band, eng_din,
    input  eng_done, eng_dout
  );

  modport slave (
    input  eng_start, eng_chan, eng_band, eng_din,
    output eng_done, eng_dout
  );

endinterface

// File: rtl/eq_band_sched.sv
// Frame scheduler: runs one stereo frame through all EQ bands on a single
// shared biquad engine (left bands first, then right), chaining each band's
// result into the next band, with a bypass path and a dropped-frame counter.
module eq_band_sched
  import eq_pkg::*;
#(
  parameter int DW     = eq_pkg::DW,
  parameter int NBANDS = eq_pkg::NBANDS,
  parameter int BW     = eq_pkg::BW
) (
  input  logic            sys_clk,
  input  logic            rstn,
  input  logic            receive_valid,
  input  logic [DW-1:0]   receive_left_data,
  input  logic [DW-1:0]   receive_right_data,
  input  logic            bypass,
  eq_band_sched_if.master eng,
  output logic            out_valid,
  output logic [DW-1:0]   out_left_data,
  output logic [DW-1:0]   out_right_data,
  output logic            overrun,
  output logic [7:0]      overrun_cnt,
  output state_t          dbg_state
);

  localparam logic [BW-1:0] LAST_BAND = BW'(NBANDS - 1);

  state_t        state_q, state_d;
  logic          chan_q, chan_d;
  logic [BW-1:0] band_q, band_d;
  logic [DW-1:0] l_q, l_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] out_l_q, out_l_d;
  logic [DW-1:0] out_r_q, out_r_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    ovr_cnt_q, ovr_cnt_d;
  logic          start_c;
  logic          out_valid_c;

  // State and datapath registers; reset also clears everything visible outside.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      chan_q    <= CH_L;
      band_q    <= '0;
      l_q       <= '0;
      r_q       <= '0;
      acc_q     <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      band_q    <= band_d;
      l_q       <= l_d;
      r_q       <= r_d;
      acc_q     <= acc_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  // Next-state, band/channel sequencing, output capture and drop counting.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    band_d      = band_q;
    l_d         = l_q;
    r_d         = r_q;
    acc_d       = acc_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    ovr_d       = 1'b0;
    ovr_cnt_d   = ovr_cnt_q;
    start_c     = 1'b0;
    out_valid_c = 1'b0;

    // Only IDLE can take a frame; anything arriving elsewhere is dropped.
    if (receive_valid && (state_q != IDLE)) begin
      ovr_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) begin
        ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (receive_valid) begin
          l_d    = receive_left_data;
          r_d    = receive_right_data;
          chan_d = CH_L;
          band_d = '0;
          if (bypass) begin
            out_l_d = receive_left_data;
            out_r_d = receive_right_data;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        start_c = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng.eng_done) begin
          acc_d = eng.eng_dout;
          if (band_q != LAST_BAND) begin
            band_d  = band_q + BW'(1);
            state_d = ISSUE;
          end else if (chan_q == CH_L) begin
            out_l_d = eng.eng_dout;
            chan_d  = CH_R;
            band_d  = '0;
            state_d = ISSUE;
          end else begin
            out_r_d = eng.eng_dout;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Band 0 of each channel starts from the latched sample; later bands chain.
  assign eng.eng_start = start_c;
  assign eng.eng_chan  = chan_q;
  assign eng.eng_band  = band_q;
  assign eng.eng_din   = (band_q == '0) ? ((chan_q == CH_L) ? l_q : r_q) : acc_q;

  assign out_valid      = out_valid_c;
  assign out_left_data  = out_l_q;
  assign out_right_data = out_r_q;
  assign overrun        = ovr_q;
  assign overrun_cnt    = ovr_cnt_q;
  assign dbg_state      = state_q;

endmodule
